// File: rtl/constraint_sample_sequencer.sv
// Rejection-sampling controller: walks a Galois LFSR, offers each candidate to an external
// combinational checker and streams the accepted candidates out on a valid/ready handshake.
module constraint_sample_sequencer #(
    parameter int               VEC_W     = 64,
    parameter int               CNT_W     = 16,
    parameter int               MAX_TRIES = 1024,
    parameter int               CHK_LAT   = 1,
    parameter logic [VEC_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             seed_load,
    input  logic [VEC_W-1:0] seed,
    output logic [VEC_W-1:0] cand_o,
    input  logic             chk_x_i,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [VEC_W-1:0] sample_data,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] accept_count,
    output logic [CNT_W-1:0] try_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_WAIT,
        S_EVAL,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [3:0]       LAT_INIT  = 4'(CHK_LAT);
    localparam logic [CNT_W-1:0] TRY_LIMIT = CNT_W'(MAX_TRIES);
    localparam logic [VEC_W-1:0] LFSR_ONE  = {{(VEC_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [VEC_W-1:0] lfsr;
    logic [VEC_W-1:0] lfsr_next;
    logic [3:0]       wait_cnt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] try_inc;
    logic [CNT_W-1:0] acc_inc;

    logic ld_seed;
    logic ld_start;
    logic ld_gen;
    logic dec_wait;
    logic ld_pass;
    logic ld_rej;
    logic ld_hs;

    // One right-shift Galois step; a non-zero state never maps to zero.
    function automatic logic [VEC_W-1:0] galois_step(input logic [VEC_W-1:0] s);
        galois_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    assign lfsr_next = galois_step(lfsr);
    assign try_inc   = try_count + CNT_W'(1);
    assign acc_inc   = accept_count + CNT_W'(1);

    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign sample_valid = (state == S_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ld_seed    = 1'b0;
        ld_start   = 1'b0;
        ld_gen     = 1'b0;
        dec_wait   = 1'b0;
        ld_pass    = 1'b0;
        ld_rej     = 1'b0;
        ld_hs      = 1'b0;
        if (abort) begin
            // Abort wins over everything else, including a pending handshake.
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    ld_seed = seed_load;
                    if (start) begin
                        ld_start   = 1'b1;
                        state_next = (n_samples == '0) ? S_DONE : S_GEN;
                    end
                end
                S_GEN: begin
                    ld_gen     = 1'b1;
                    state_next = S_WAIT;
                end
                S_WAIT: begin
                    dec_wait = 1'b1;
                    if (wait_cnt == 4'd1) begin
                        state_next = S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (chk_x_i) begin
                        ld_pass    = 1'b1;
                        state_next = S_OUT;
                    end else begin
                        ld_rej     = 1'b1;
                        state_next = (try_inc == TRY_LIMIT) ? S_DONE : S_GEN;
                    end
                end
                S_OUT: begin
                    if (sample_ready) begin
                        ld_hs      = 1'b1;
                        state_next = (acc_inc == target) ? S_DONE : S_GEN;
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // LFSR persists across runs; only reset or an explicit seed reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_ONE;
        end else if (ld_seed) begin
            lfsr <= (seed == '0) ? LFSR_ONE : seed;
        end else if (ld_gen) begin
            lfsr <= lfsr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_o   <= '0;
            wait_cnt <= '0;
        end else if (ld_gen) begin
            cand_o   <= lfsr_next;
            wait_cnt <= LAT_INIT;
        end else if (dec_wait) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_data <= '0;
        end else if (ld_pass) begin
            sample_data <= cand_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target       <= '0;
            accept_count <= '0;
            try_count    <= '0;
            fail         <= 1'b0;
        end else begin
            if (ld_start) begin
                target       <= n_samples;
                accept_count <= '0;
                try_count    <= '0;
                fail         <= 1'b0;
            end
            if (ld_rej) begin
                try_count <= try_inc;
                if (try_inc == TRY_LIMIT) begin
                    fail <= 1'b1;
                end
            end
            if (ld_hs) begin
                accept_count <= acc_inc;
                try_count    <= '0;
            end
        end
    end

endmodule
